// File: rtl/mult_rom_serial_param.sv
// mult_rom_serial_param: serial digit-by-digit multiplier built on one 4x4 product LUT
module mult_rom_serial_param #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [WIDTH-1:0]   mult1,
  input  logic [WIDTH-1:0]   mult2,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [2*WIDTH-1:0] dout,
  output logic               busy
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  generate
    if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
      $error("mult_rom_serial_param: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0]   a, b, ma, mb;
  logic               neg, last;
  logic [CW-1:0]      i, j;
  logic [7:0]         pp;
  logic [2*WIDTH-1:0] acc, ppx, sum;
  logic [CW+2:0]      sh;
  function automatic logic [7:0] lut(input logic [3:0] x, input logic [3:0] y);
    return {4'b0, x} * {4'b0, y};
  endfunction
  assign ma   = (SIGNED != 0 && mult1[WIDTH-1]) ? -mult1 : mult1;
  assign mb   = (SIGNED != 0 && mult2[WIDTH-1]) ? -mult2 : mult2;
  assign last = (i == LAST) && (j == LAST);
  assign pp   = lut(a[4*i +: 4], b[4*j +: 4]);
  assign ppx  = (2*WIDTH)'(pp);
  assign sh   = {({1'b0, i} + {1'b0, j}), 2'b00};
  assign sum  = acc + (ppx << sh);
  assign din_ready  = state == IDLE;
  assign dout_valid = state == DONE;
  assign busy       = state != IDLE;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = din_valid ? CALC : IDLE;
      CALC:    nxt = last ? DONE : CALC;
      DONE:    nxt = dout_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // operand capture, digit walk, accumulation and result load
  always_ff @(posedge clk) begin
    if (rst) begin
      a    <= '0;
      b    <= '0;
      neg  <= 1'b0;
      acc  <= '0;
      i    <= '0;
      j    <= '0;
      dout <= '0;
    end else if (state == IDLE && din_valid) begin
      a   <= ma;
      b   <= mb;
      neg <= (SIGNED != 0) && (mult1[WIDTH-1] ^ mult2[WIDTH-1]);
      acc <= '0;
      i   <= '0;
      j   <= '0;
    end else if (state == CALC) begin
      acc <= sum;
      j   <= (j == LAST) ? '0 : j + 1'b1;
      i   <= last ? '0 : (j == LAST) ? i + 1'b1 : i;
      if (last) dout <= neg ? -sum : sum;
    end
  end
endmodule
